// File: rtl/accel_uart_pkg.sv
// Shared opcodes, bridge state encoding and the CRC-8 step (poly 0x07, MSB-first).
// Used by the bridge RTL; the step function is pure so it folds to XOR trees.
package accel_uart_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_NAK = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_EXEC,
    ST_RESP,
    ST_NAK
  } state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/csr_uart_bridge_if.sv
// Byte streams to/from the UART plus the CSR strobe bus and status pulses.
// master = the bridge; slave = the UART/CSR side facing it.
interface csr_uart_bridge_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              crc_en;
  logic              csr_wen;
  logic              csr_ren;
  logic [ADDR_W-1:0] csr_addr;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              rx_crc_error;
  logic              rx_illegal_cmd;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, crc_en, csr_rdata,
    output rx_ready, tx_data, tx_valid, csr_wen, csr_ren, csr_addr, csr_wdata,
           rx_crc_error, rx_illegal_cmd, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, crc_en, csr_rdata,
    input  rx_ready, tx_data, tx_valid, csr_wen, csr_ren, csr_addr, csr_wdata,
           rx_crc_error, rx_illegal_cmd, busy
  );
endinterface

// File: rtl/csr_uart_bridge.sv
// UART command-frame parser driving single-cycle CSR strobes and ACK/NAK/read-data replies.
// Strobe one cycle after the last frame byte; reply starts the cycle after; rx stalls while replying.
module csr_uart_bridge
  import accel_uart_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  csr_uart_bridge_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic              is_rd;
  logic [1:0]        data_idx;
  logic [7:0]        crc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [7:0]        rsp_crc_q;
  logic [2:0]        rsp_idx;
  logic [TW-1:0]     tmo_q;
  logic              crc_err_q;
  logic              ill_q;

  logic              rx_rdy, tx_vld, wen, ren, busy_o;
  logic [7:0]        tx_dat;
  logic              rx_fire, tx_fire, in_frame, tmo_hit;
  logic              is_op, crc_bad, misaligned, rsp_last;
  logic [7:0]        rd_crc;

  assign rx_fire    = bus.rx_valid && rx_rdy;
  assign tx_fire    = tx_vld && bus.tx_ready;
  assign in_frame   = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CRC);
  assign tmo_hit    = in_frame && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign is_op      = (bus.rx_data == OP_WR) || (bus.rx_data == OP_RD);
  assign crc_bad    = bus.crc_en && (crc_q != bus.rx_data);
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign rsp_last   = is_rd ? (rsp_idx == 3'd5) : (rsp_idx == 3'd0);

  // Reply CRC covers the ACK byte followed by the four read-data bytes.
  always_comb begin
    rd_crc = crc8_step(8'h00, RSP_ACK);
    for (int i = 0; i < 4; i++) begin
      rd_crc = crc8_step(rd_crc, bus.csr_rdata[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_rdy    = 1'b0;
    tx_vld    = 1'b0;
    tx_dat    = 8'h00;
    wen       = 1'b0;
    ren       = 1'b0;
    busy_o    = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        rx_rdy = 1'b1;
        if (rx_fire) state_nxt = is_op ? ST_ADDR : ST_NAK;
      end
      ST_ADDR: begin
        rx_rdy = 1'b1;
        if (rx_fire)      state_nxt = is_rd ? ST_CRC : ST_DATA;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        rx_rdy = 1'b1;
        if (rx_fire) begin
          if (data_idx == 2'd3) state_nxt = ST_CRC;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CRC: begin
        rx_rdy = 1'b1;
        if (rx_fire)      state_nxt = (crc_bad || misaligned) ? ST_NAK : ST_EXEC;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_EXEC: begin
        wen       = !is_rd;
        ren       = is_rd;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        tx_vld = 1'b1;
        case (rsp_idx)
          3'd0:    tx_dat = RSP_ACK;
          3'd1:    tx_dat = rdata_q[7:0];
          3'd2:    tx_dat = rdata_q[15:8];
          3'd3:    tx_dat = rdata_q[23:16];
          3'd4:    tx_dat = rdata_q[31:24];
          default: tx_dat = rsp_crc_q;
        endcase
        if (tx_fire && rsp_last) state_nxt = ST_IDLE;
      end
      ST_NAK: begin
        tx_vld = 1'b1;
        tx_dat = RSP_NAK;
        if (tx_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rd     <= 1'b0;
      data_idx  <= 2'd0;
      crc_q     <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      rsp_crc_q <= 8'h00;
      rsp_idx   <= 3'd0;
      tmo_q     <= '0;
      crc_err_q <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      ill_q     <= 1'b0;
      // Idle gap counter only runs while a frame is partially received.
      if (rx_fire || !in_frame) tmo_q <= '0;
      else                      tmo_q <= tmo_q + 1'b1;
      case (state)
        ST_IDLE: if (rx_fire) begin
          is_rd    <= (bus.rx_data == OP_RD);
          crc_q    <= crc8_step(8'h00, bus.rx_data);
          data_idx <= 2'd0;
          if (!is_op) ill_q <= 1'b1;
        end
        ST_ADDR: if (rx_fire) begin
          addr_q <= ADDR_W'(bus.rx_data);
          crc_q  <= crc8_step(crc_q, bus.rx_data);
        end
        ST_DATA: if (rx_fire) begin
          wdata_q[8*data_idx +: 8] <= bus.rx_data;
          data_idx                 <= data_idx + 2'd1;
          crc_q                    <= crc8_step(crc_q, bus.rx_data);
        end
        ST_CRC: if (rx_fire) begin
          if (crc_bad)         crc_err_q <= 1'b1;
          else if (misaligned) ill_q     <= 1'b1;
        end
        ST_EXEC: begin
          rsp_idx <= 3'd0;
          if (is_rd) begin
            rdata_q   <= bus.csr_rdata;
            rsp_crc_q <= rd_crc;
          end
        end
        ST_RESP: if (tx_fire) rsp_idx <= rsp_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready       = rx_rdy;
  assign bus.tx_valid       = tx_vld;
  assign bus.tx_data        = tx_dat;
  assign bus.csr_wen        = wen;
  assign bus.csr_ren        = ren;
  assign bus.csr_addr       = addr_q;
  assign bus.csr_wdata      = wdata_q;
  assign bus.rx_crc_error   = crc_err_q;
  assign bus.rx_illegal_cmd = ill_q;
  assign bus.busy           = busy_o;

endmodule
